// File: rtl/input_hub.sv
// Controls/config front end between hps_io and the game core: keymapped PS/2
// keys merged with joysticks, SOCD cleaning, coin stretching, pause, DIP/game latches.
module input_hub #(
    parameter int           PLAYERS      = 2,
    parameter int           BUTTONS      = 3,
    parameter int           DIP_BANKS    = 2,
    parameter int           COIN_CYCLES  = 16,
    parameter bit           SOCD_CLEAR   = 1'b1,
    parameter bit           PAUSE_TOGGLE = 1'b1,
    parameter logic [7:0]   KEYMAP_INDEX = 8'd2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [10:0]                    ps2_key,
    input  logic [PLAYERS*(7+BUTTONS)-1:0] joystick,
    input  logic [24:0]                    ioctl_addr,
    input  logic [7:0]                     ioctl_data,
    input  logic                           ioctl_wr,
    input  logic [7:0]                     ioctl_index,
    output logic [PLAYERS*4-1:0]           joy,
    output logic [PLAYERS*BUTTONS-1:0]     buttons,
    output logic [PLAYERS-1:0]             start,
    output logic [PLAYERS-1:0]             coin,
    output logic                           pause,
    output logic [DIP_BANKS*8-1:0]         dip,
    output logic [3:0]                     game_index
);

    localparam int SLOTS   = 6 + BUTTONS;
    localparam int ENTRIES = PLAYERS * SLOTS;
    localparam int JW      = 7 + BUTTONS;
    localparam int CW      = $clog2(COIN_CYCLES + 1);

    // Defaults are laid out for three buttons; extra buttons get 00, start/coin keep their codes.
    function automatic logic [7:0] keymapDefault(input int p, input int s);
        int         k;
        logic [7:0] code;
        if (s < 4)                 k = s;
        else if (s < 4 + BUTTONS)  k = (s < 7) ? s : -1;
        else                       k = s - BUTTONS + 3;
        code = 8'h00;
        if (p == 0) begin
            case (k)
                0: code = 8'h75;  1: code = 8'h72;  2: code = 8'h6B;
                3: code = 8'h74;  4: code = 8'h14;  5: code = 8'h11;
                6: code = 8'h29;  7: code = 8'h16;  8: code = 8'h2E;
                default: code = 8'h00;
            endcase
        end else if (p == 1) begin
            case (k)
                0: code = 8'h2D;  1: code = 8'h2B;  2: code = 8'h23;
                3: code = 8'h34;  4: code = 8'h1C;  5: code = 8'h1B;
                6: code = 8'h15;  7: code = 8'h1E;  8: code = 8'h36;
                default: code = 8'h00;
            endcase
        end
        return code;
    endfunction

    logic [7:0]                   keymapQ [ENTRIES];
    logic [7:0]                   keymapD [ENTRIES];
    logic [ENTRIES-1:0]           keyQ, keyD;
    logic                         strobeQ;
    logic                         keyEvent;
    logic [PLAYERS-1:0][CW-1:0]   coinCntQ, coinCntD;
    logic [PLAYERS-1:0]           coinPrevQ, rawCoin;
    logic                         pausePrevQ, rawPause;
    logic [PLAYERS-1:0]           up, down, left, right;
    logic [PLAYERS*4-1:0]         joyQ, joyD;
    logic [PLAYERS*BUTTONS-1:0]   buttonsQ, buttonsD;
    logic [PLAYERS-1:0]           startQ, startD, coinQ, coinD;
    logic                         pauseQ, pauseD;
    logic [DIP_BANKS*8-1:0]       dipQ, dipD;
    logic [3:0]                   gameIndexQ, gameIndexD;
    logic                         unusedPs2Bit;

    assign unusedPs2Bit = ps2_key[8];

    // Key events compare against the stored keymap, so a same-cycle load only affects later events.
    always_comb begin
        keymapD  = keymapQ;
        keyD     = keyQ;
        keyEvent = ps2_key[10] ^ strobeQ;
        for (int e = 0; e < ENTRIES; e++) begin
            if (keyEvent && ps2_key[7:0] != 8'h00 && keymapQ[e] == ps2_key[7:0])
                keyD[e] = ps2_key[9];
            if (ioctl_wr && ioctl_index == KEYMAP_INDEX && ioctl_addr == 25'(e))
                keymapD[e] = ioctl_data;
        end
    end

    always_comb begin
        joyD     = '0;
        buttonsD = '0;
        startD   = '0;
        coinD    = '0;
        coinCntD = coinCntQ;
        rawCoin  = '0;
        rawPause = 1'b0;
        up       = '0;
        down     = '0;
        left     = '0;
        right    = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            up[p]    = keyQ[p*SLOTS + 0] | joystick[p*JW + 3];
            down[p]  = keyQ[p*SLOTS + 1] | joystick[p*JW + 2];
            left[p]  = keyQ[p*SLOTS + 2] | joystick[p*JW + 1];
            right[p] = keyQ[p*SLOTS + 3] | joystick[p*JW + 0];
            if (SOCD_CLEAR && up[p] && down[p]) begin
                up[p]   = 1'b0;
                down[p] = 1'b0;
            end
            if (SOCD_CLEAR && left[p] && right[p]) begin
                left[p]  = 1'b0;
                right[p] = 1'b0;
            end
            joyD[p*4 +: 4] = {up[p], down[p], right[p], left[p]};
            for (int b = 0; b < BUTTONS; b++)
                buttonsD[p*BUTTONS + b] = keyQ[p*SLOTS + 4 + b] | joystick[p*JW + 4 + b];
            startD[p]  = keyQ[p*SLOTS + 4 + BUTTONS] | joystick[p*JW + 4 + BUTTONS];
            rawCoin[p] = keyQ[p*SLOTS + 5 + BUTTONS] | joystick[p*JW + 5 + BUTTONS];
            // Using the next count keeps the high time at exactly COIN_CYCLES for a one-cycle pulse.
            if (rawCoin[p] && !coinPrevQ[p])
                coinCntD[p] = CW'(COIN_CYCLES);
            else if (coinCntQ[p] != '0)
                coinCntD[p] = coinCntQ[p] - CW'(1);
            coinD[p] = rawCoin[p] | (coinCntD[p] != '0);
            rawPause = rawPause | joystick[p*JW + 6 + BUTTONS];
        end
        pauseD = PAUSE_TOGGLE ? (pauseQ ^ (rawPause & ~pausePrevQ)) : rawPause;
    end

    always_comb begin
        dipD       = dipQ;
        gameIndexD = gameIndexQ;
        for (int k = 0; k < DIP_BANKS; k++) begin
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 25'(k))
                dipD[k*8 +: 8] = ioctl_data;
        end
        if (ioctl_wr && ioctl_index == 8'd1)
            gameIndexD = ioctl_data[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < ENTRIES; e++)
                keymapQ[e] <= keymapDefault(e / SLOTS, e % SLOTS);
            keyQ       <= '0;
            strobeQ    <= 1'b0;
            coinCntQ   <= '0;
            coinPrevQ  <= '0;
            pausePrevQ <= 1'b0;
            joyQ       <= '0;
            buttonsQ   <= '0;
            startQ     <= '0;
            coinQ      <= '0;
            pauseQ     <= 1'b0;
            dipQ       <= '0;
            gameIndexQ <= '0;
        end else begin
            keymapQ    <= keymapD;
            keyQ       <= keyD;
            strobeQ    <= ps2_key[10];
            coinCntQ   <= coinCntD;
            coinPrevQ  <= rawCoin;
            pausePrevQ <= rawPause;
            joyQ       <= joyD;
            buttonsQ   <= buttonsD;
            startQ     <= startD;
            coinQ      <= coinD;
            pauseQ     <= pauseD;
            dipQ       <= dipD;
            gameIndexQ <= gameIndexD;
        end
    end

    assign joy        = joyQ;
    assign buttons    = buttonsQ;
    assign start      = startQ;
    assign coin       = coinQ;
    assign pause      = pauseQ;
    assign dip        = dipQ;
    assign game_index = gameIndexQ;

endmodule

// File: tb/tb_input_hub.sv
// Directed bench for input_hub: keymapped keys, SOCD, coin stretch, pause and ioctl latches.
module tb_input_hub;

    localparam int PLAYERS = 2;
    localparam int BUTTONS = 3;
    localparam int JWTOT   = PLAYERS * (7 + BUTTONS);

    logic               clk = 1'b0;
    logic               reset_n;
    logic [10:0]        ps2_key;
    logic [JWTOT-1:0]   joystick;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_data;
    logic               ioctl_wr;
    logic [7:0]         ioctl_index;
    logic [7:0]         joy;
    logic [5:0]         buttons;
    logic [1:0]         start, coin;
    logic               pause;
    logic [15:0]        dip;
    logic [3:0]         game_index;

    logic [7:0]         unusedJoy2;
    logic [5:0]         unusedButtons2;
    logic [1:0]         unusedStart2, unusedCoin2;
    logic               pause2;
    logic [15:0]        unusedDip2;
    logic [3:0]         unusedGame2;

    int compared   = 0;
    int mismatched = 0;
    int high;

    always #5 clk = ~clk;

    input_hub dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .joy(joy), .buttons(buttons), .start(start),
        .coin(coin), .pause(pause), .dip(dip), .game_index(game_index)
    );

    input_hub #(.PAUSE_TOGGLE(1'b0)) dutLevel (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .joy(unusedJoy2), .buttons(unusedButtons2),
        .start(unusedStart2), .coin(unusedCoin2), .pause(pause2), .dip(unusedDip2),
        .game_index(unusedGame2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic strobe, input logic pressed, input logic [7:0] code, input int cycles);
        ps2_key = {strobe, pressed, 1'b0, code};
        repeat (cycles) tick();
    endtask

    task automatic ioctlWrite(input logic [7:0] index, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = index;
        ioctl_addr  = addr;
        ioctl_data  = data;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; ps2_key = '0; joystick = '0;
        ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0; ioctl_index = '0;
        repeat (2) tick();
        checkOutput("rstJoy", 32'(joy), 32'h0);
        checkOutput("rstCoin", 32'(coin), 32'h0);
        checkOutput("rstPause", 32'(pause), 32'h0);
        checkOutput("rstDip", 32'(dip), 32'h0);
        checkOutput("rstGame", 32'(game_index), 32'h0);
        reset_n = 1'b1;
        tick();

        $display("[TB] key press/release through default keymap");
        applyStimulus(1'b1, 1'b1, 8'h75, 1);
        checkOutput("keyUpLatency1", 32'(joy[3]), 32'h0);
        tick();
        checkOutput("keyUpPressed", 32'(joy[3]), 32'h1);
        repeat (3) tick();
        checkOutput("keyUpHeld", 32'(joy[3]), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h75, 2);
        checkOutput("keyUpReleased", 32'(joy[3]), 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h75, 3);
        checkOutput("noToggleNoEvent", 32'(joy[3]), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h2D, 2);
        checkOutput("p1UpKey", 32'(joy), 32'h80);
        applyStimulus(1'b0, 1'b0, 8'h2D, 2);

        $display("[TB] keymap reload");
        ioctlWrite(8'd2, 25'd0, 8'h1D);
        applyStimulus(1'b1, 1'b1, 8'h75, 2);
        checkOutput("oldCodeIgnored", 32'(joy[3]), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h75, 1);
        applyStimulus(1'b1, 1'b1, 8'h1D, 2);
        checkOutput("newCodeUp", 32'(joy[3]), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h1D, 2);
        checkOutput("newCodeRelease", 32'(joy[3]), 32'h0);

        $display("[TB] joystick merge and SOCD");
        joystick = 20'b1110;
        tick();
        checkOutput("socdUpDown", 32'(joy[3:0]), 32'h1);
        joystick = 20'b1111;
        tick();
        checkOutput("socdAll", 32'(joy[3:0]), 32'h0);
        joystick = 20'b0000_1001_0000 | (20'b1 << 13);
        tick();
        checkOutput("joyButtons", 32'(buttons), 32'h01);
        checkOutput("joyStart", 32'(start), 32'h1);
        checkOutput("joyP1Up", 32'(joy), 32'h80);
        joystick = '0;
        tick();

        $display("[TB] coin stretcher");
        joystick[8] = 1'b1;
        tick();
        joystick[8] = 1'b0;
        high = 0;
        for (int i = 0; i < 40; i++) begin
            if (coin[0]) high++;
            tick();
        end
        checkOutput("coinSingle", 32'(high), 32'd16);
        joystick[8] = 1'b1;
        tick();
        joystick[8] = 1'b0;
        high = 0;
        for (int i = 0; i < 60; i++) begin
            if (coin[0]) high++;
            if (i == 9) joystick[8] = 1'b1;
            tick();
            if (i == 9) joystick[8] = 1'b0;
        end
        checkOutput("coinRetrigger", 32'(high), 32'd26);

        $display("[TB] pause toggle and level");
        joystick[9] = 1'b1;
        tick();
        checkOutput("pausePress1", 32'(pause), 32'h1);
        checkOutput("pauseLevelHi", 32'(pause2), 32'h1);
        joystick[9] = 1'b0;
        tick();
        checkOutput("pauseHold1", 32'(pause), 32'h1);
        checkOutput("pauseLevelLo", 32'(pause2), 32'h0);
        joystick[19] = 1'b1;
        tick();
        checkOutput("pausePress2", 32'(pause), 32'h0);
        repeat (2) tick();
        checkOutput("pauseHeldNoRetoggle", 32'(pause), 32'h0);
        joystick[19] = 1'b0;
        tick();
        joystick[9] = 1'b1;
        tick();
        joystick[9] = 1'b0;
        tick();
        checkOutput("pausePress3", 32'(pause), 32'h1);

        $display("[TB] DIP banks and game index");
        ioctlWrite(8'd254, 25'd0, 8'hA5);
        ioctlWrite(8'd254, 25'd1, 8'h3C);
        ioctlWrite(8'd254, 25'd9, 8'hFF);
        ioctlWrite(8'd1, 25'd0, 8'h05);
        ioctlWrite(8'd1, 25'd0, 8'h17);
        tick();
        checkOutput("dipBanks", 32'(dip), 32'h3CA5);
        checkOutput("gameIndex", 32'(game_index), 32'h7);

        $display("[TB] reset mid-download");
        ioctl_index = 8'd254; ioctl_addr = 25'd0; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
        reset_n = 1'b0;
        #1;
        checkOutput("rstDip2", 32'(dip), 32'h0);
        checkOutput("rstGame2", 32'(game_index), 32'h0);
        checkOutput("rstPause2", 32'(pause), 32'h0);
        tick();
        checkOutput("rstWriteIgnored", 32'(dip), 32'h0);
        reset_n = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        checkOutput("writeAfterReset", 32'(dip), 32'h005A);
        applyStimulus(1'b1, 1'b1, 8'h75, 2);
        checkOutput("keymapRestored", 32'(joy[3]), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h75, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
